lut_reg_pipe: RTL and testbench

Parametrised successor to the fixed 6-input registered-AND CLB benchmark. It registers N_IN inputs and applies a run-time-selectable reduction (AND, OR, XOR or INIT-programmed LUT). The result passes through OUT_STAGES output registers, with a valid bit carried alongside and a global clock enable. A saturating hit counter lets the bench and the board check true-result activity without probing the pipeline.

---
 rtl/lut_reg_pkg.sv | 18 +
 rtl/lut_reg_pipe_if.sv | 37 +++
 rtl/pipe_stage.sv | 29 ++
 rtl/lut_reg_pipe.sv | 107 ++++++++++
 tb/tb_lut_reg_pipe.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/lut_reg_pkg.sv
// lut_reg_pkg: shared types and constants for the lut_reg_pipe block.
//   mode_e       - reduction selector carried with each sampled operand
//   INIT_DEFAULT - LUT table equal to a 6-input AND (only entry 63 is 1)
package lut_reg_pkg;

   typedef enum logic [1:0] {
      MODE_AND = 2'd0,
      MODE_OR  = 2'd1,
      MODE_XOR = 2'd2,
      MODE_LUT = 2'd3
   } mode_e;

   localparam logic [63:0] INIT_DEFAULT = 64'h8000_0000_0000_0000;

   // Widest input vector the LUT mode can address.
   localparam int unsigned MAX_N_IN = 6;

endpackage

// File: rtl/lut_reg_pipe_if.sv
// lut_reg_pipe_if: operand/result bundle for lut_reg_pipe.
//   ce        - global clock enable
//   in_valid  - qualifies in_data/mode
//   in_data   - operand vector (N_IN bits)
//   mode      - reduction selector
//   cnt_clr   - synchronous hit counter clear (not gated by ce)
//   out_data  - registered reduction result
//   out_valid - valid aligned with out_data
//   hit_count - saturating count of emitted valid ones
// master drives operands, slave is the pipeline.
interface lut_reg_pipe_if
   import lut_reg_pkg::*;
#(
   parameter int unsigned N_IN  = 6,
   parameter int unsigned CNT_W = 16
);

   logic              ce;
   logic              in_valid;
   logic [N_IN-1:0]   in_data;
   mode_e             mode;
   logic              cnt_clr;
   logic              out_data;
   logic              out_valid;
   logic [CNT_W-1:0]  hit_count;

   modport master (
      output ce, in_valid, in_data, mode, cnt_clr,
      input  out_data, out_valid, hit_count
   );

   modport slave (
      input  ce, in_valid, in_data, mode, cnt_clr,
      output out_data, out_valid, hit_count
   );

endinterface

// File: rtl/pipe_stage.sv
// pipe_stage: W-bit register with clock enable and asynchronous reset to 0.
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   ce  - load enable; low holds the current value
//   d   - next value
//   q   - registered value
module pipe_stage #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ce,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= '0;
      end else if (ce) begin
         q_q <= d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/lut_reg_pipe.sv
// lut_reg_pipe: registered N_IN-input reduction (AND/OR/XOR/LUT) followed by
// OUT_STAGES output registers, with a valid bit carried alongside and a
// saturating hit counter. Latency is 1 + OUT_STAGES enabled cycles.
//   clock0 - rising-edge clock
//   reset  - asynchronous active-high reset, clears all state
//   bus    - lut_reg_pipe_if slave: ce, in_valid, in_data, mode, cnt_clr,
//            out_data, out_valid, hit_count
module lut_reg_pipe
   import lut_reg_pkg::*;
#(
   parameter int unsigned N_IN       = 6,
   parameter int unsigned OUT_STAGES = 2,
   parameter logic [63:0] INIT       = INIT_DEFAULT,
   parameter int unsigned CNT_W      = 16
) (
   input  logic           clock0,
   input  logic           reset,
   lut_reg_pipe_if.slave  bus
);

   if (N_IN < 2 || N_IN > MAX_N_IN) begin : g_bad_n_in
      $error("lut_reg_pipe: N_IN must be in 2..6");
   end
   if (OUT_STAGES < 1) begin : g_bad_out_stages
      $error("lut_reg_pipe: OUT_STAGES must be at least 1");
   end

   localparam int unsigned S0_W = N_IN + 3;

   // Stage 0: data, mode and valid are captured together so a mode change
   // only ever applies to the operand sampled in the same cycle.
   logic [S0_W-1:0]      s0_d;
   logic [S0_W-1:0]      s0_q;
   logic [N_IN-1:0]      s0_data;
   mode_e                s0_mode;
   logic                 s0_valid;

   assign s0_d = {bus.in_valid, bus.mode, bus.in_data};

   pipe_stage #(
      .W (S0_W)
   ) u_stage0 (
      .clk (clock0),
      .rst (reset),
      .ce  (bus.ce),
      .d   (s0_d),
      .q   (s0_q)
   );

   assign s0_data  = s0_q[N_IN-1:0];
   assign s0_mode  = mode_e'(s0_q[N_IN +: 2]);
   assign s0_valid = s0_q[S0_W-1];

   // Reduction straight off the stage-0 registers.
   logic [MAX_N_IN-1:0] lut_idx;
   logic                red;

   always_comb begin
      lut_idx            = '0;
      lut_idx[N_IN-1:0]  = s0_data;
      red                = 1'b0;
      unique case (s0_mode)
         MODE_AND: red = &s0_data;
         MODE_OR:  red = |s0_data;
         MODE_XOR: red = ^s0_data;
         MODE_LUT: red = INIT[lut_idx];
      endcase
   end

   // Output chain of {result, valid}; element 0 is the combinational input,
   // element OUT_STAGES is what leaves the block.
   logic [1:0] chain [OUT_STAGES+1];

   assign chain[0] = {red, s0_valid};

   for (genvar i = 0; i < OUT_STAGES; i++) begin : g_out_stage
      pipe_stage #(
         .W (2)
      ) u_stage (
         .clk (clock0),
         .rst (reset),
         .ce  (bus.ce),
         .d   (chain[i]),
         .q   (chain[i+1])
      );
   end

   assign bus.out_data  = chain[OUT_STAGES][1];
   assign bus.out_valid = chain[OUT_STAGES][0];

   // Counts the pair being presented at the edge it is shifted out, so a
   // stalled pair is only counted once. Clear wins over increment.
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clock0 or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (bus.cnt_clr) begin
         cnt_q <= '0;
      end else if (bus.ce && bus.out_valid && bus.out_data && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bus.hit_count = cnt_q;

endmodule

// File: tb/tb_lut_reg_pipe.sv
// Self-checking bench: three configurations of lut_reg_pipe share one random
// stimulus stream and are compared every cycle against a latency-queue model.
//   a: defaults (N_IN=6, OUT_STAGES=2, AND table, CNT_W=16)
//   b: N_IN=6, OUT_STAGES=2, irregular LUT table
//   c: N_IN=3, OUT_STAGES=1, CNT_W=4
module tb_lut_reg_pipe;
   import lut_reg_pkg::*;

   localparam logic [63:0] INIT_B = 64'hA5C3_0F96_3C5A_0024;
   localparam logic [63:0] INIT_C = 64'h0000_0000_0000_006B;

   logic       clock0   = 1'b0;
   logic       reset    = 1'b1;
   logic       ce       = 1'b0;
   logic       in_valid = 1'b0;
   logic       cnt_clr  = 1'b0;
   logic [5:0] in_data  = '0;
   logic [1:0] mode     = '0;

   always #5 clock0 = ~clock0;

   lut_reg_pipe_if #(.N_IN(6), .CNT_W(16)) if_a ();
   lut_reg_pipe_if #(.N_IN(6), .CNT_W(16)) if_b ();
   lut_reg_pipe_if #(.N_IN(3), .CNT_W(4))  if_c ();

   assign if_a.ce = ce;
   assign if_a.in_valid = in_valid;
   assign if_a.in_data = in_data;
   assign if_a.mode = mode_e'(mode);
   assign if_a.cnt_clr = cnt_clr;
   assign if_b.ce = ce;
   assign if_b.in_valid = in_valid;
   assign if_b.in_data = in_data;
   assign if_b.mode = mode_e'(mode);
   assign if_b.cnt_clr = cnt_clr;
   assign if_c.ce = ce;
   assign if_c.in_valid = in_valid;
   assign if_c.in_data = in_data[2:0];
   assign if_c.mode = mode_e'(mode);
   assign if_c.cnt_clr = cnt_clr;

   lut_reg_pipe #(.N_IN(6), .OUT_STAGES(2), .INIT(INIT_DEFAULT), .CNT_W(16)) dut_a (
      .clock0 (clock0), .reset (reset), .bus (if_a)
   );
   lut_reg_pipe #(.N_IN(6), .OUT_STAGES(2), .INIT(INIT_B), .CNT_W(16)) dut_b (
      .clock0 (clock0), .reset (reset), .bus (if_b)
   );
   lut_reg_pipe #(.N_IN(3), .OUT_STAGES(1), .INIT(INIT_C), .CNT_W(4)) dut_c (
      .clock0 (clock0), .reset (reset), .bus (if_c)
   );

   logic        od [3];
   logic        ov [3];
   logic [15:0] hc [3];

   assign od[0] = if_a.out_data;
   assign od[1] = if_b.out_data;
   assign od[2] = if_c.out_data;
   assign ov[0] = if_a.out_valid;
   assign ov[1] = if_b.out_valid;
   assign ov[2] = if_c.out_valid;
   assign hc[0] = if_a.hit_count;
   assign hc[1] = if_b.hit_count;
   assign hc[2] = {12'd0, if_c.hit_count};

   // Reference model: each configuration is a delay line of lat entries;
   // index 0 is what is currently presented on the outputs.
   int unsigned n_in [3]   = '{6, 6, 3};
   int unsigned lat  [3]   = '{3, 3, 2};
   int unsigned cmax [3]   = '{65535, 65535, 15};
   logic [63:0] init_t [3] = '{INIT_DEFAULT, INIT_B, INIT_C};
   logic [1:0]  dl [3][3];
   int unsigned cnt [3];

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic ref_res(input int d, input logic [5:0] data, input logic [1:0] m);
      logic [5:0] x;
      int         pc;
      x  = data & 6'((64'd1 << n_in[d]) - 64'd1);
      pc = $countones(x);
      case (m)
         2'd0:    return pc == int'(n_in[d]);
         2'd1:    return pc != 0;
         2'd2:    return (pc % 2) == 1;
         default: return init_t[d][x];
      endcase
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         cnt[d] = 0;
         for (int i = 0; i < 3; i++) dl[d][i] = 2'b00;
      end
   endtask

   task automatic compare_all();
      for (int d = 0; d < 3; d++) begin
         check($sformatf("out_data[%0d]", d), 32'(od[d]), 32'(dl[d][0][1]));
         check($sformatf("out_valid[%0d]", d), 32'(ov[d]), 32'(dl[d][0][0]));
         check($sformatf("hit_count[%0d]", d), 32'(hc[d]), cnt[d]);
      end
   endtask

   task automatic cycle();
      @(posedge clock0);
      if (!reset) begin
         for (int d = 0; d < 3; d++) begin
            if (cnt_clr) cnt[d] = 0;
            else if (ce && dl[d][0] == 2'b11 && cnt[d] < cmax[d]) cnt[d]++;
            if (ce) begin
               for (int i = 0; i < int'(lat[d]) - 1; i++) dl[d][i] = dl[d][i+1];
               dl[d][lat[d]-1] = {ref_res(d, in_data, mode), in_valid};
            end
         end
      end
      #1;
      compare_all();
   endtask

   task automatic drive(input logic c, input logic v, input logic [1:0] m,
                        input logic [5:0] dat, input logic clr);
      ce = c; in_valid = v; mode = m; in_data = dat; cnt_clr = clr;
      cycle();
   endtask

   // Asynchronous reset pulse starting between edges, held across one edge.
   task automatic reset_pulse();
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("async_rst.out_valid[%0d]", d), 32'(ov[d]), 32'd0);
         check($sformatf("async_rst.hit_count[%0d]", d), 32'(hc[d]), 32'd0);
      end
      cycle();
      reset = 1'b0;
   endtask

   initial begin
      logic [3:0] sweep_exp;
      model_reset();
      repeat (2) @(posedge clock0);
      #1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("reset.out_data[%0d]", d), 32'(od[d]), 32'd0);
         check($sformatf("reset.out_valid[%0d]", d), 32'(ov[d]), 32'd0);
         check($sformatf("reset.hit_count[%0d]", d), 32'(hc[d]), 32'd0);
      end
      reset = 1'b0;

      // AND smoke on defaults: 3F -> 1 three cycles later, 3E -> 0.
      drive(1'b1, 1'b1, 2'd0, 6'h3F, 1'b0);
      drive(1'b1, 1'b0, 2'd0, 6'h00, 1'b0);
      check("smoke.early_valid", 32'(ov[0]), 32'd0);
      drive(1'b1, 1'b0, 2'd0, 6'h00, 1'b0);
      check("smoke.and3f_data", 32'(od[0]), 32'd1);
      check("smoke.and3f_valid", 32'(ov[0]), 32'd1);
      drive(1'b1, 1'b1, 2'd0, 6'h3E, 1'b0);
      drive(1'b1, 1'b0, 2'd0, 6'h00, 1'b0);
      drive(1'b1, 1'b0, 2'd0, 6'h00, 1'b0);
      check("smoke.and3e_data", 32'(od[0]), 32'd0);
      check("smoke.and3e_valid", 32'(ov[0]), 32'd1);

      // Mode changes every cycle on 000101: AND 0, OR 1, XOR 0, LUT(b) 1.
      sweep_exp = 4'b1010;
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, k < 4, (k < 4) ? 2'(k) : 2'd0, 6'b000101, 1'b0);
         if (k >= 2) check($sformatf("sweep.mode%0d", k - 2), 32'(od[1]), 32'(sweep_exp[k-2]));
      end

      // Four items with a two-cycle ce stall after the second.
      drive(1'b1, 1'b1, 2'd1, 6'h01, 1'b0);
      drive(1'b1, 1'b1, 2'd2, 6'h07, 1'b0);
      drive(1'b0, 1'b1, 2'd0, 6'h3F, 1'b0);
      drive(1'b0, 1'b1, 2'd0, 6'h3F, 1'b0);
      drive(1'b1, 1'b1, 2'd3, 6'h05, 1'b0);
      drive(1'b1, 1'b1, 2'd0, 6'h3F, 1'b0);
      repeat (4) drive(1'b1, 1'b0, 2'd0, 6'h00, 1'b0);

      // Reset with three items in flight; nothing stale may emerge.
      drive(1'b1, 1'b1, 2'd0, 6'h3F, 1'b0);
      drive(1'b1, 1'b1, 2'd1, 6'h3F, 1'b0);
      drive(1'b1, 1'b1, 2'd2, 6'h01, 1'b0);
      reset_pulse();
      repeat (4) drive(1'b1, 1'b0, 2'd0, 6'h3F, 1'b0);

      // Saturation of the 4-bit counter, then clear coinciding with a hit.
      repeat (20) drive(1'b1, 1'b1, 2'd0, 6'h3F, 1'b0);
      check("cnt.saturated_c", 32'(hc[2]), 32'd15);
      drive(1'b1, 1'b1, 2'd0, 6'h3F, 1'b1);
      check("cnt.clear_c", 32'(hc[2]), 32'd0);
      check("cnt.clear_a", 32'(hc[0]), 32'd0);
      drive(1'b1, 1'b1, 2'd0, 6'h3F, 1'b0);
      check("cnt.after_clear_c", 32'(hc[2]), 32'd1);

      // XOR of 111 on the short pipe, then invalid slots.
      drive(1'b1, 1'b1, 2'd2, 6'h07, 1'b0);
      drive(1'b1, 1'b0, 2'd2, 6'h07, 1'b0);
      check("xor3.data_c", 32'(od[2]), 32'd1);
      check("xor3.valid_c", 32'(ov[2]), 32'd1);
      drive(1'b1, 1'b0, 2'd2, 6'h07, 1'b0);
      check("xor3.invalid_valid_c", 32'(ov[2]), 32'd0);

      // Random traffic with stalls, clears and the odd reset.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            reset_pulse();
         end else begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom), 6'($urandom),
                  $urandom_range(0, 63) == 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
